mmio_responder: RTL and testbench

- Single-outstanding memory-mapped responder that services CPU data loads/stores addressed below 0x8000_0000, i.e. the accesses the difftest commit path marks as skip.
- Sits between rvcpu's bus request port and the top level, alongside the RAM path.
- Implements a CLINT-style timer (mtime, mtimecmp, timer interrupt) and a byte UART port that drives the top-level uart out/in signals.

---
 rtl/mmio_responder_if.sv | 24 ++
 rtl/mmio_responder.sv | 148 ++++++++++++++
 tb/tb_mmio_responder.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_responder_if.sv
// Request/response bus between the CPU data port and the MMIO responder.
// A beat transfers on a rising clock edge where valid & ready are both high; valid holds its payload until then.
interface mmio_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [63:0] req_wmask;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_wmask, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/mmio_responder.sv
// Single-outstanding MMIO responder: CLINT-style mtime/mtimecmp timer plus a byte UART port.
// Requests are serviced in the accept cycle and answered exactly one cycle later.
module mmio_responder #(
    parameter int unsigned TICK_DIV   = 1,
    parameter logic [63:0] CLINT_BASE = 64'h0000_0000_0200_0000,
    parameter logic [63:0] UART_BASE  = 64'h0000_0000_1000_0000
) (
    input  logic                   clock,
    input  logic                   reset_n,
    mmio_responder_if.slave        bus,
    output logic                   timer_irq,
    output logic                   uart_out_valid,
    output logic [7:0]             uart_out_ch,
    output logic                   uart_in_valid,
    input  logic [7:0]             uart_in_ch,
    output logic                   dbg_state
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } state_e;

    localparam logic [60:0] MTIMECMP_IDX = 61'((CLINT_BASE + 64'h4000) >> 3);
    localparam logic [60:0] MTIME_IDX    = 61'((CLINT_BASE + 64'hBFF8) >> 3);
    localparam logic [60:0] UART_IDX     = 61'(UART_BASE >> 3);
    localparam logic [15:0] TICK_LAST    = 16'(TICK_DIV - 1);

    state_e      state_q, state_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [63:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic [15:0] presc_q, presc_d;
    logic        irq_q, irq_d;
    logic        uart_out_valid_q, uart_out_valid_d;
    logic [7:0]  uart_out_ch_q, uart_out_ch_d;

    logic        accept;
    logic        is_cmp, is_mtime, is_uart;
    logic        tick;
    logic [63:0] load_data;
    logic        unused_addr_lsb;

    function automatic logic [63:0] wmerge(input logic [63:0] old_v,
                                           input logic [63:0] data,
                                           input logic [63:0] mask);
        return (old_v & ~mask) | (data & mask);
    endfunction

    always_comb begin
        accept   = bus.req_valid & req_ready_q;
        is_cmp   = (bus.req_addr[63:3] == MTIMECMP_IDX);
        is_mtime = (bus.req_addr[63:3] == MTIME_IDX);
        is_uart  = (bus.req_addr[63:3] == UART_IDX);

        tick    = (presc_q == TICK_LAST);
        presc_d = tick ? 16'd0 : presc_q + 16'd1;
        // A store to mtime below overrides the tick; the prescaler keeps its phase.
        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
        mtimecmp_d = mtimecmp_q;
        irq_d      = (mtime_q >= mtimecmp_q);

        load_data = 64'd0;
        if (is_cmp)        load_data = mtimecmp_q;
        else if (is_mtime) load_data = mtime_q;
        else if (is_uart)  load_data = {56'd0, uart_in_ch};

        state_d          = state_q;
        req_ready_d      = req_ready_q;
        resp_valid_d     = resp_valid_q;
        resp_rdata_d     = resp_rdata_q;
        resp_err_d       = resp_err_q;
        uart_out_valid_d = 1'b0;
        uart_out_ch_d    = uart_out_ch_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d      = S_RESP;
                    req_ready_d  = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = ~(is_cmp | is_mtime | is_uart);
                    resp_rdata_d = bus.req_wen ? 64'd0 : load_data;
                    if (bus.req_wen) begin
                        if (is_cmp)   mtimecmp_d = wmerge(mtimecmp_q, bus.req_wdata, bus.req_wmask);
                        if (is_mtime) mtime_d    = wmerge(mtime_q, bus.req_wdata, bus.req_wmask);
                        if (is_uart && (bus.req_wmask[7:0] != 8'd0)) begin
                            uart_out_valid_d = 1'b1;
                            uart_out_ch_d    = bus.req_wdata[7:0];
                        end
                    end
                end
            end
            default: begin
                if (resp_valid_q && bus.resp_ready) begin
                    state_d      = S_IDLE;
                    req_ready_d  = 1'b1;
                    resp_valid_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= S_IDLE;
            req_ready_q      <= 1'b1;
            resp_valid_q     <= 1'b0;
            resp_rdata_q     <= 64'd0;
            resp_err_q       <= 1'b0;
            mtime_q          <= 64'd0;
            mtimecmp_q       <= 64'hFFFF_FFFF_FFFF_FFFF;
            presc_q          <= 16'd0;
            irq_q            <= 1'b0;
            uart_out_valid_q <= 1'b0;
            uart_out_ch_q    <= 8'd0;
        end else begin
            state_q          <= state_d;
            req_ready_q      <= req_ready_d;
            resp_valid_q     <= resp_valid_d;
            resp_rdata_q     <= resp_rdata_d;
            resp_err_q       <= resp_err_d;
            mtime_q          <= mtime_d;
            mtimecmp_q       <= mtimecmp_d;
            presc_q          <= presc_d;
            irq_q            <= irq_d;
            uart_out_valid_q <= uart_out_valid_d;
            uart_out_ch_q    <= uart_out_ch_d;
        end
    end

    // RX strobe is combinational so uart_in_ch is sampled in the accept cycle itself.
    assign uart_in_valid   = accept & ~bus.req_wen & is_uart;
    assign unused_addr_lsb = ^bus.req_addr[2:0];

    assign bus.req_ready   = req_ready_q;
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_rdata  = resp_rdata_q;
    assign bus.resp_err    = resp_err_q;
    assign timer_irq       = irq_q;
    assign uart_out_valid  = uart_out_valid_q;
    assign uart_out_ch     = uart_out_ch_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_mmio_responder.sv
// Bench for mmio_responder: two instances (TICK_DIV 1 and 4) receive identical requests;
// a spec-level reference model supplies expected load data through per-instance queues.
module tb_mmio_responder;
  localparam logic [63:0] A_CMP   = 64'h0000_0000_0200_4000;
  localparam logic [63:0] A_MTIME = 64'h0000_0000_0200_BFF8;
  localparam logic [63:0] A_UART  = 64'h0000_0000_1000_0000;
  localparam logic [63:0] A_BAD   = 64'h0000_0000_0300_0000;
  localparam logic [63:0] ONES    = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_wen, resp_ready;
  logic [63:0] req_addr, req_wdata, req_wmask;
  logic [7:0]  uart_in_ch;
  logic        irq0, irq1, tx_v0, tx_v1, rx_v0, rx_v1, dbg0, dbg1;
  logic [7:0]  tx_c0, tx_c1;

  int checks = 0;
  int failures = 0;
  logic [64:0] exp0_q[$];
  logic [64:0] exp1_q[$];

  always #5 clk = ~clk;

  mmio_responder_if bus0();
  mmio_responder_if bus1();

  assign bus0.req_valid = req_valid;  assign bus1.req_valid = req_valid;
  assign bus0.req_wen   = req_wen;    assign bus1.req_wen   = req_wen;
  assign bus0.req_addr  = req_addr;   assign bus1.req_addr  = req_addr;
  assign bus0.req_wdata = req_wdata;  assign bus1.req_wdata = req_wdata;
  assign bus0.req_wmask = req_wmask;  assign bus1.req_wmask = req_wmask;
  assign bus0.resp_ready = resp_ready; assign bus1.resp_ready = resp_ready;

  mmio_responder #(.TICK_DIV(1)) u_dut0 (
    .clock(clk), .reset_n(rst_n), .bus(bus0), .timer_irq(irq0),
    .uart_out_valid(tx_v0), .uart_out_ch(tx_c0), .uart_in_valid(rx_v0),
    .uart_in_ch(uart_in_ch), .dbg_state(dbg0)
  );

  mmio_responder #(.TICK_DIV(4)) u_dut1 (
    .clock(clk), .reset_n(rst_n), .bus(bus1), .timer_irq(irq1),
    .uart_out_valid(tx_v1), .uart_out_ch(tx_c1), .uart_in_valid(rx_v1),
    .uart_in_ch(uart_in_ch), .dbg_state(dbg1)
  );

  // ---------------- reference model ----------------
  logic        m_ready, m_irq0, m_irq1, m_acc;
  logic [63:0] m_mtime0, m_mtime1, m_cmp;
  logic [1:0]  m_presc1;

  function automatic logic [1:0] kind(input logic [63:0] a);
    if (a[63:3] == A_CMP[63:3]) return 2'd0;
    if (a[63:3] == A_MTIME[63:3]) return 2'd1;
    if (a[63:3] == A_UART[63:3]) return 2'd2;
    return 2'd3;
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] o, input logic [63:0] d, input logic [63:0] m);
    return (o & ~m) | (d & m);
  endfunction

  assign m_acc = req_valid & m_ready;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ready  <= 1'b1;
      m_mtime0 <= 64'd0;
      m_mtime1 <= 64'd0;
      m_cmp    <= ONES;
      m_presc1 <= 2'd0;
      m_irq0   <= 1'b0;
      m_irq1   <= 1'b0;
    end else begin
      if (m_acc) m_ready <= 1'b0;
      else if (!m_ready && resp_ready) m_ready <= 1'b1;
      m_presc1 <= m_presc1 + 2'd1;
      m_irq0   <= (m_mtime0 >= m_cmp);
      m_irq1   <= (m_mtime1 >= m_cmp);
      if (m_acc && req_wen && kind(req_addr) == 2'd1) begin
        m_mtime0 <= merge(m_mtime0, req_wdata, req_wmask);
        m_mtime1 <= merge(m_mtime1, req_wdata, req_wmask);
      end else begin
        m_mtime0 <= m_mtime0 + 64'd1;
        m_mtime1 <= m_mtime1 + ((m_presc1 == 2'd3) ? 64'd1 : 64'd0);
      end
      if (m_acc && req_wen && kind(req_addr) == 2'd0)
        m_cmp <= merge(m_cmp, req_wdata, req_wmask);
    end
  end

  // ---------------- driver: one full request/response transaction ----------------
  task automatic do_req(input string name, input logic wen, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [63:0] wmask, input int hold,
                        output logic [63:0] rd0, output logic [63:0] rd1);
    logic [64:0] e0, e1;
    logic [1:0]  k;
    logic        exp_rx, exp_tx;
    k = kind(addr);
    case (k)
      2'd0:    begin e0 = {1'b0, m_cmp};    e1 = {1'b0, m_cmp};    end
      2'd1:    begin e0 = {1'b0, m_mtime0}; e1 = {1'b0, m_mtime1}; end
      2'd2:    begin e0 = {1'b0, 56'd0, uart_in_ch}; e1 = e0;      end
      default: begin e0 = {1'b1, 64'd0};    e1 = e0;               end
    endcase
    if (wen) begin e0[63:0] = 64'd0; e1[63:0] = 64'd0; end
    exp0_q.push_back(e0);
    exp1_q.push_back(e1);
    exp_rx = !wen && (k == 2'd2);
    exp_tx = wen && (k == 2'd2) && (wmask[7:0] != 8'd0);
    rd0 = '0;
    rd1 = '0;

    req_wen = wen; req_addr = addr; req_wdata = wdata; req_wmask = wmask; req_valid = 1'b1;
    #1;
    checks++; if ({bus0.req_ready, bus1.req_ready} !== 2'b11) begin failures++; $display("FAIL %s_ready_idle got=%b exp=11", name, {bus0.req_ready, bus1.req_ready}); end
    checks++; if ({rx_v0, rx_v1} !== {exp_rx, exp_rx}) begin failures++; $display("FAIL %s_rx_strobe got=%b exp=%b", name, {rx_v0, rx_v1}, {exp_rx, exp_rx}); end

    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++; if ({bus0.resp_valid, bus1.resp_valid, bus0.req_ready, bus1.req_ready} !== 4'b1100) begin failures++; $display("FAIL %s_latency got=%b exp=1100", name, {bus0.resp_valid, bus1.resp_valid, bus0.req_ready, bus1.req_ready}); end
    checks++; if ({tx_v0, tx_v1, rx_v0, rx_v1} !== {exp_tx, exp_tx, 2'b00}) begin failures++; $display("FAIL %s_uart_strobe got=%b exp=%b", name, {tx_v0, tx_v1, rx_v0, rx_v1}, {exp_tx, exp_tx, 2'b00}); end
    if (exp_tx) begin
      checks++; if ({tx_c0, tx_c1} !== {wdata[7:0], wdata[7:0]}) begin failures++; $display("FAIL %s_tx_ch got=%h exp=%h", name, {tx_c0, tx_c1}, {wdata[7:0], wdata[7:0]}); end
    end

    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checks++; if ({bus0.resp_valid, bus1.resp_valid, bus0.req_ready, bus1.req_ready, tx_v0, tx_v1} !== 6'b110000) begin failures++; $display("FAIL %s_hold%0d got=%b exp=110000", name, i, {bus0.resp_valid, bus1.resp_valid, bus0.req_ready, bus1.req_ready, tx_v0, tx_v1}); end
      checks++; if ({bus0.resp_err, bus0.resp_rdata, bus1.resp_err, bus1.resp_rdata} !== {exp0_q[0], exp1_q[0]}) begin failures++; $display("FAIL %s_hold_data%0d got=%h exp=%h", name, i, {bus0.resp_err, bus0.resp_rdata, bus1.resp_err, bus1.resp_rdata}, {exp0_q[0], exp1_q[0]}); end
    end

    resp_ready = 1'b1;
    if (exp0_q.size() == 0 || exp1_q.size() == 0) begin
      failures++; $display("FAIL %s_queue empty", name);
    end else begin
      e0 = exp0_q.pop_front();
      e1 = exp1_q.pop_front();
      checks++; if ({bus0.resp_err, bus0.resp_rdata} !== e0) begin failures++; $display("FAIL %s_resp0 got=%h exp=%h", name, {bus0.resp_err, bus0.resp_rdata}, e0); end
      checks++; if ({bus1.resp_err, bus1.resp_rdata} !== e1) begin failures++; $display("FAIL %s_resp1 got=%h exp=%h", name, {bus1.resp_err, bus1.resp_rdata}, e1); end
    end
    rd0 = bus0.resp_rdata;
    rd1 = bus1.resp_rdata;

    @(posedge clk); #1;
    resp_ready = 1'b0;
    checks++; if ({bus0.resp_valid, bus1.resp_valid, bus0.req_ready, bus1.req_ready, tx_v0, tx_v1, dbg0, dbg1} !== 8'b00110000) begin failures++; $display("FAIL %s_done got=%b exp=00110000", name, {bus0.resp_valid, bus1.resp_valid, bus0.req_ready, bus1.req_ready, tx_v0, tx_v1, dbg0, dbg1}); end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [63:0] rd0, rd1;
    rst_n = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0; req_wmask = '0;
    resp_ready = 1'b0; uart_in_ch = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({bus0.req_ready, bus1.req_ready, bus0.resp_valid, bus1.resp_valid, bus0.resp_err, bus1.resp_err} !== 6'b110000) begin failures++; $display("FAIL reset_handshake got=%b exp=110000", {bus0.req_ready, bus1.req_ready, bus0.resp_valid, bus1.resp_valid, bus0.resp_err, bus1.resp_err}); end
    checks++; if ({bus0.resp_rdata, bus1.resp_rdata} !== 128'd0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", {bus0.resp_rdata, bus1.resp_rdata}); end
    checks++; if ({irq0, irq1, tx_v0, tx_v1, rx_v0, rx_v1, dbg0, dbg1, tx_c0, tx_c1} !== 24'd0) begin failures++; $display("FAIL reset_outputs got=%h exp=0", {irq0, irq1, tx_v0, tx_v1, rx_v0, rx_v1, dbg0, dbg1, tx_c0, tx_c1}); end
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    do_req("reset_mtime", 1'b0, A_MTIME, 64'd0, 64'd0, 0, rd0, rd1);
    checks++; if (!(rd0 == 64'd9 || rd0 == 64'd10)) begin failures++; $display("FAIL reset_mtime_range got=%0d exp=9or10", rd0); end
  endtask

  task automatic test_timer();
    logic [63:0] rd0, rd1;
    do_req("timer_clr_mtime", 1'b1, A_MTIME, 64'd0, ONES, 0, rd0, rd1);
    do_req("timer_set_cmp", 1'b1, A_CMP, 64'd20, ONES, 0, rd0, rd1);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      checks++; if ({irq0, irq1} !== {m_irq0, m_irq1}) begin failures++; $display("FAIL timer_irq_cyc%0d got=%b exp=%b", i, {irq0, irq1}, {m_irq0, m_irq1}); end
    end
    do_req("timer_cmp_max", 1'b1, A_CMP, ONES, ONES, 0, rd0, rd1);
    checks++; if ({irq0, irq1} !== 2'b00) begin failures++; $display("FAIL timer_irq_clear got=%b exp=00", {irq0, irq1}); end
  endtask

  task automatic test_partial_mask();
    logic [63:0] rd0, rd1;
    do_req("mask_full", 1'b1, A_CMP, 64'h1122_3344_5566_7788, ONES, 0, rd0, rd1);
    do_req("mask_low", 1'b1, A_CMP, 64'd0, 64'h0000_0000_FFFF_FFFF, 0, rd0, rd1);
    do_req("mask_read", 1'b0, A_CMP, 64'd0, 64'd0, 0, rd0, rd1);
    checks++; if ({rd0, rd1} !== {64'h1122_3344_0000_0000, 64'h1122_3344_0000_0000}) begin failures++; $display("FAIL mask_value got=%h exp=%h", {rd0, rd1}, {64'h1122_3344_0000_0000, 64'h1122_3344_0000_0000}); end
    do_req("mask_restore", 1'b1, A_CMP, ONES, ONES, 0, rd0, rd1);
  endtask

  task automatic test_collision();
    logic [63:0] rd0, rd1;
    for (int i = 0; i < 8 && m_presc1 != 2'd3; i++) begin @(posedge clk); #1; end
    checks++; if (m_presc1 !== 2'd3) begin failures++; $display("FAIL collision_sync got=%0d exp=3", m_presc1); end
    do_req("coll_store", 1'b1, A_MTIME, 64'hFFFF_FFFF_FFFF_FFFE, ONES, 0, rd0, rd1);
    do_req("coll_read", 1'b0, A_MTIME, 64'd0, 64'd0, 0, rd0, rd1);
    checks++; if (rd1 !== 64'hFFFF_FFFF_FFFF_FFFE) begin failures++; $display("FAIL coll_written got=%h exp=fffffffffffffffe", rd1); end
    repeat (5) @(posedge clk);
    #1;
    do_req("coll_wrap", 1'b0, A_MTIME, 64'd0, 64'd0, 0, rd0, rd1);
    checks++; if (rd1 !== 64'd0) begin failures++; $display("FAIL coll_wrapped got=%h exp=0", rd1); end
    for (int i = 0; i < 8 && m_presc1 != 2'd1; i++) begin @(posedge clk); #1; end
    do_req("presc_store", 1'b1, A_MTIME, 64'd100, ONES, 0, rd0, rd1);
    @(posedge clk); #1;
    do_req("presc_phase", 1'b0, A_MTIME, 64'd0, 64'd0, 0, rd0, rd1);
  endtask

  task automatic test_uart();
    logic [63:0] rd0, rd1;
    uart_in_ch = 8'h5A;
    do_req("uart_tx", 1'b1, A_UART, 64'h41, ONES, 0, rd0, rd1);
    do_req("uart_tx_nomask", 1'b1, A_UART, 64'h42, 64'hFFFF_FF00, 0, rd0, rd1);
    do_req("uart_rx", 1'b0, A_UART, 64'd0, 64'd0, 0, rd0, rd1);
    checks++; if ({rd0, rd1} !== {64'h5A, 64'h5A}) begin failures++; $display("FAIL uart_rx_data got=%h exp=5a", {rd0, rd1}); end
    uart_in_ch = 8'($urandom_range(0, 255));
    do_req("uart_rx_rand", 1'b0, A_UART, 64'd0, 64'd0, 1, rd0, rd1);
  endtask

  task automatic test_backpressure();
    logic [63:0] rd0, rd1;
    do_req("unmapped_load", 1'b0, A_BAD, 64'd0, 64'd0, 5, rd0, rd1);
    checks++; if ({rd0, rd1} !== 128'd0) begin failures++; $display("FAIL unmapped_rdata got=%h exp=0", {rd0, rd1}); end
    do_req("unmapped_store", 1'b1, A_BAD, 64'hDEAD, ONES, 2, rd0, rd1);
  endtask

  task automatic test_back_to_back();
    logic [64:0] e;
    exp0_q.push_back({1'b0, m_cmp});
    exp1_q.push_back({1'b0, m_cmp});
    req_wen = 1'b0; req_addr = A_CMP; req_valid = 1'b1;
    @(posedge clk); #1;
    req_addr = A_BAD;
    resp_ready = 1'b1;
    e = exp0_q.pop_front();
    checks++; if ({bus0.resp_valid, bus0.resp_err, bus0.resp_rdata} !== {1'b1, e}) begin failures++; $display("FAIL b2b_first0 got=%h exp=%h", {bus0.resp_valid, bus0.resp_err, bus0.resp_rdata}, {1'b1, e}); end
    e = exp1_q.pop_front();
    checks++; if ({bus1.resp_valid, bus1.resp_err, bus1.resp_rdata} !== {1'b1, e}) begin failures++; $display("FAIL b2b_first1 got=%h exp=%h", {bus1.resp_valid, bus1.resp_err, bus1.resp_rdata}, {1'b1, e}); end
    @(posedge clk); #1;
    checks++; if ({bus0.resp_valid, bus1.resp_valid, bus0.req_ready, bus1.req_ready} !== 4'b0011) begin failures++; $display("FAIL b2b_gap got=%b exp=0011", {bus0.resp_valid, bus1.resp_valid, bus0.req_ready, bus1.req_ready}); end
    exp0_q.push_back({1'b1, 64'd0});
    exp1_q.push_back({1'b1, 64'd0});
    @(posedge clk); #1;
    req_valid = 1'b0;
    e = exp0_q.pop_front();
    checks++; if ({bus0.resp_valid, bus0.resp_err, bus0.resp_rdata} !== {1'b1, e}) begin failures++; $display("FAIL b2b_second0 got=%h exp=%h", {bus0.resp_valid, bus0.resp_err, bus0.resp_rdata}, {1'b1, e}); end
    e = exp1_q.pop_front();
    checks++; if ({bus1.resp_valid, bus1.resp_err, bus1.resp_rdata} !== {1'b1, e}) begin failures++; $display("FAIL b2b_second1 got=%h exp=%h", {bus1.resp_valid, bus1.resp_err, bus1.resp_rdata}, {1'b1, e}); end
    @(posedge clk); #1;
    resp_ready = 1'b0;
    checks++; if ({bus0.resp_valid, bus1.resp_valid, bus0.req_ready, bus1.req_ready} !== 4'b0011) begin failures++; $display("FAIL b2b_end got=%b exp=0011", {bus0.resp_valid, bus1.resp_valid, bus0.req_ready, bus1.req_ready}); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] rd0, rd1;
    req_wen = 1'b1; req_addr = A_UART; req_wdata = 64'h55; req_wmask = ONES; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++; if ({bus0.resp_valid, bus1.resp_valid, tx_v0, tx_v1} !== 4'b1111) begin failures++; $display("FAIL midrst_pre got=%b exp=1111", {bus0.resp_valid, bus1.resp_valid, tx_v0, tx_v1}); end
    rst_n = 1'b0;
    #1;
    checks++; if ({bus0.resp_valid, bus1.resp_valid, tx_v0, tx_v1, bus0.req_ready, bus1.req_ready, dbg0, dbg1} !== 8'b00001100) begin failures++; $display("FAIL midrst_abort got=%b exp=00001100", {bus0.resp_valid, bus1.resp_valid, tx_v0, tx_v1, bus0.req_ready, bus1.req_ready, dbg0, dbg1}); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++; if ({tx_v0, tx_v1, bus0.resp_valid, bus1.resp_valid} !== 4'b0000) begin failures++; $display("FAIL midrst_quiet%0d got=%b exp=0000", i, {tx_v0, tx_v1, bus0.resp_valid, bus1.resp_valid}); end
    end
    do_req("midrst_cmp", 1'b0, A_CMP, 64'd0, 64'd0, 0, rd0, rd1);
    checks++; if ({rd0, rd1} !== {ONES, ONES}) begin failures++; $display("FAIL midrst_cmp_reset got=%h exp=all_ones", {rd0, rd1}); end
    do_req("midrst_mtime", 1'b0, A_MTIME, 64'd0, 64'd0, 0, rd0, rd1);
  endtask

  initial begin
    test_reset();
    test_timer();
    test_partial_mask();
    test_collision();
    test_uart();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    checks++; if (exp0_q.size() != 0 || exp1_q.size() != 0) begin failures++; $display("FAIL queue_leftover got=%0d/%0d exp=0", exp0_q.size(), exp1_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
